// File: rtl/fpu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fpu_op_sequencer
// Brief    : Issue-side controller for the shared FP multiply, divide and
//            add/sub units. Accepts one op at a time and pulses the unit
//            starts. Chains multiply into add for the fused ops. Returns a
//            tagged result, and aborts a unit that never signals done.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_op_sequencer #(
    parameter int TAG_W          = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    // issue handshake
    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  logic [4:0]       float_op_i,
    input  logic [31:0]      operand1_i,
    input  logic [31:0]      operand2_i,
    input  logic [31:0]      operand3_i,
    input  logic [TAG_W-1:0] tag_i,
    // unit start pulses and operands
    output logic             mul_start_o,
    output logic             div_start_o,
    output logic             add_start_o,
    output logic [31:0]      mul_op1_o,
    output logic [31:0]      mul_op2_o,
    output logic [31:0]      div_op1_o,
    output logic [31:0]      div_op2_o,
    output logic [31:0]      add_op1_o,
    output logic [31:0]      add_op2_o,
    output logic             add_sub_o,
    // unit completion
    input  logic             mul_done_i,
    input  logic             div_done_i,
    input  logic             add_done_i,
    input  logic [31:0]      mul_result_i,
    input  logic [31:0]      div_result_i,
    input  logic [31:0]      add_result_i,
    // writeback
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic [31:0]      result_o,
    output logic [TAG_W-1:0] result_tag_o,
    output logic             error_o,
    output logic             illegal_op_o,
    output logic             busy_o
);

    localparam logic [4:0]  c_op_fmadd  = 5'd2;
    localparam logic [4:0]  c_op_fmsub  = 5'd3;
    localparam logic [4:0]  c_op_fnmsub = 5'd4;
    localparam logic [4:0]  c_op_fnmadd = 5'd5;
    localparam logic [4:0]  c_op_fadd   = 5'd6;
    localparam logic [4:0]  c_op_fsub   = 5'd7;
    localparam logic [4:0]  c_op_fmul   = 5'd8;
    localparam logic [4:0]  c_op_fdiv   = 5'd9;
    localparam logic [31:0] c_qnan      = 32'h7FC0_0000;

    localparam int              c_wd_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL_WAIT = 3'd1,
        S_ADD_WAIT = 3'd2,
        S_DIV_WAIT = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    state_t              r_state;
    logic [4:0]          r_op;
    logic [31:0]         r_rs3;
    logic [TAG_W-1:0]    r_tag;
    logic [c_wd_w-1:0]   r_wd;
    logic                r_mul_start;
    logic                r_div_start;
    logic                r_add_start;
    logic [31:0]         r_mul_op1;
    logic [31:0]         r_mul_op2;
    logic [31:0]         r_div_op1;
    logic [31:0]         r_div_op2;
    logic [31:0]         r_add_op1;
    logic [31:0]         r_add_op2;
    logic                r_add_sub;
    logic                r_valid;
    logic [31:0]         r_result;
    logic                r_error;
    logic                r_illegal;

    // Fused-op second phase: negate the product for FNMSUB/FNMADD,
    // subtract rs3 for FMSUB/FNMADD.
    logic w_neg_prod;
    logic w_fused_sub;
    logic w_wd_expired;

    assign w_neg_prod   = (r_op == c_op_fnmsub) || (r_op == c_op_fnmadd);
    assign w_fused_sub  = (r_op == c_op_fmsub)  || (r_op == c_op_fnmadd);
    assign w_wd_expired = (r_wd == c_wd_last);

    // Sequencer FSM, watchdog and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_rs3       <= '0;
            r_tag       <= '0;
            r_wd        <= '0;
            r_mul_start <= 1'b0;
            r_div_start <= 1'b0;
            r_add_start <= 1'b0;
            r_mul_op1   <= '0;
            r_mul_op2   <= '0;
            r_div_op1   <= '0;
            r_div_op2   <= '0;
            r_add_op1   <= '0;
            r_add_op2   <= '0;
            r_add_sub   <= 1'b0;
            r_valid     <= 1'b0;
            r_result    <= '0;
            r_error     <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            // pulses are single-cycle unless re-armed below
            r_mul_start <= 1'b0;
            r_div_start <= 1'b0;
            r_add_start <= 1'b0;
            r_illegal   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (issue_valid_i) begin
                        r_op  <= float_op_i;
                        r_rs3 <= operand3_i;
                        r_tag <= tag_i;
                        r_wd  <= '0;
                        case (float_op_i)
                            c_op_fmadd, c_op_fmsub, c_op_fnmsub,
                            c_op_fnmadd, c_op_fmul: begin
                                r_mul_op1   <= operand1_i;
                                r_mul_op2   <= operand2_i;
                                r_mul_start <= 1'b1;
                                r_state     <= S_MUL_WAIT;
                            end
                            c_op_fadd, c_op_fsub: begin
                                r_add_op1   <= operand1_i;
                                r_add_op2   <= operand2_i;
                                r_add_sub   <= (float_op_i == c_op_fsub);
                                r_add_start <= 1'b1;
                                r_state     <= S_ADD_WAIT;
                            end
                            c_op_fdiv: begin
                                r_div_op1   <= operand1_i;
                                r_div_op2   <= operand2_i;
                                r_div_start <= 1'b1;
                                r_state     <= S_DIV_WAIT;
                            end
                            default: begin
                                r_illegal <= 1'b1;
                            end
                        endcase
                    end
                end

                S_MUL_WAIT: begin
                    if (mul_done_i) begin
                        if (r_op == c_op_fmul) begin
                            r_result <= mul_result_i;
                            r_error  <= 1'b0;
                            r_valid  <= 1'b1;
                            r_state  <= S_RESP;
                        end else begin
                            r_add_op1   <= {mul_result_i[31] ^ w_neg_prod, mul_result_i[30:0]};
                            r_add_op2   <= r_rs3;
                            r_add_sub   <= w_fused_sub;
                            r_add_start <= 1'b1;
                            r_wd        <= '0;
                            r_state     <= S_ADD_WAIT;
                        end
                    end else if (w_wd_expired) begin
                        r_result <= c_qnan;
                        r_error  <= 1'b1;
                        r_valid  <= 1'b1;
                        r_state  <= S_RESP;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end

                S_ADD_WAIT: begin
                    if (add_done_i) begin
                        r_result <= add_result_i;
                        r_error  <= 1'b0;
                        r_valid  <= 1'b1;
                        r_state  <= S_RESP;
                    end else if (w_wd_expired) begin
                        r_result <= c_qnan;
                        r_error  <= 1'b1;
                        r_valid  <= 1'b1;
                        r_state  <= S_RESP;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end

                S_DIV_WAIT: begin
                    if (div_done_i) begin
                        r_result <= div_result_i;
                        r_error  <= 1'b0;
                        r_valid  <= 1'b1;
                        r_state  <= S_RESP;
                    end else if (w_wd_expired) begin
                        r_result <= c_qnan;
                        r_error  <= 1'b1;
                        r_valid  <= 1'b1;
                        r_state  <= S_RESP;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end

                S_RESP: begin
                    if (result_ready_i) begin
                        r_valid <= 1'b0;
                        r_error <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign issue_ready_o  = (r_state == S_IDLE);
    assign busy_o         = (r_state != S_IDLE);
    assign mul_start_o    = r_mul_start;
    assign div_start_o    = r_div_start;
    assign add_start_o    = r_add_start;
    assign mul_op1_o      = r_mul_op1;
    assign mul_op2_o      = r_mul_op2;
    assign div_op1_o      = r_div_op1;
    assign div_op2_o      = r_div_op2;
    assign add_op1_o      = r_add_op1;
    assign add_op2_o      = r_add_op2;
    assign add_sub_o      = r_add_sub;
    assign result_valid_o = r_valid;
    assign result_o       = r_result;
    assign result_tag_o   = r_tag;
    assign error_o        = r_error;
    assign illegal_op_o   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_fpu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_op_sequencer
// Brief    : Directed self-checking bench for fpu_op_sequencer; unit stubs are
//            driven inline with hand-chosen latencies and results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_op_sequencer;

    localparam int TAG_W          = 5;
    localparam int TIMEOUT_CYCLES = 16;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             issue_valid_i;
    logic             issue_ready_o;
    logic [4:0]       float_op_i;
    logic [31:0]      operand1_i, operand2_i, operand3_i;
    logic [TAG_W-1:0] tag_i;
    logic             mul_start_o, div_start_o, add_start_o;
    logic [31:0]      mul_op1_o, mul_op2_o, div_op1_o, div_op2_o, add_op1_o, add_op2_o;
    logic             add_sub_o;
    logic             mul_done_i, div_done_i, add_done_i;
    logic [31:0]      mul_result_i, div_result_i, add_result_i;
    logic             result_valid_o;
    logic             result_ready_i;
    logic [31:0]      result_o;
    logic [TAG_W-1:0] result_tag_o;
    logic             error_o, illegal_op_o, busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    fpu_op_sequencer #(
        .TAG_W          (TAG_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .issue_valid_i  (issue_valid_i),
        .issue_ready_o  (issue_ready_o),
        .float_op_i     (float_op_i),
        .operand1_i     (operand1_i),
        .operand2_i     (operand2_i),
        .operand3_i     (operand3_i),
        .tag_i          (tag_i),
        .mul_start_o    (mul_start_o),
        .div_start_o    (div_start_o),
        .add_start_o    (add_start_o),
        .mul_op1_o      (mul_op1_o),
        .mul_op2_o      (mul_op2_o),
        .div_op1_o      (div_op1_o),
        .div_op2_o      (div_op2_o),
        .add_op1_o      (add_op1_o),
        .add_op2_o      (add_op2_o),
        .add_sub_o      (add_sub_o),
        .mul_done_i     (mul_done_i),
        .div_done_i     (div_done_i),
        .add_done_i     (add_done_i),
        .mul_result_i   (mul_result_i),
        .div_result_i   (div_result_i),
        .add_result_i   (add_result_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_o       (result_o),
        .result_tag_o   (result_tag_o),
        .error_o        (error_o),
        .illegal_op_o   (illegal_op_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    // Present one op for a single edge; returns at the negedge of cycle N+1.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [TAG_W-1:0] t);
        issue_valid_i = 1'b1;
        float_op_i    = op;
        operand1_i    = a;
        operand2_i    = b;
        operand3_i    = c;
        tag_i         = t;
        tick();
        issue_valid_i = 1'b0;
    endtask

    // Called at the negedge of the start cycle S; done is high in cycle S+lat.
    task automatic pulse_done(input int unit, input int lat, input logic [31:0] res);
        repeat (lat) tick();
        case (unit)
            0: begin mul_done_i = 1'b1; mul_result_i = res; end
            1: begin div_done_i = 1'b1; div_result_i = res; end
            default: begin add_done_i = 1'b1; add_result_i = res; end
        endcase
        tick();
        mul_done_i = 1'b0;
        div_done_i = 1'b0;
        add_done_i = 1'b0;
    endtask

    task automatic handshake();
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
    endtask

    logic [4:0]  fz_op  [4];
    logic [31:0] fz_op1 [4];
    logic        fz_sub [4];

    initial begin
        fz_op[0] = 5'd2; fz_op1[0] = 32'h40C0_0000; fz_sub[0] = 1'b0;
        fz_op[1] = 5'd3; fz_op1[1] = 32'h40C0_0000; fz_sub[1] = 1'b1;
        fz_op[2] = 5'd4; fz_op1[2] = 32'hC0C0_0000; fz_sub[2] = 1'b0;
        fz_op[3] = 5'd5; fz_op1[3] = 32'hC0C0_0000; fz_sub[3] = 1'b1;

        rst_i = 1'b0; issue_valid_i = 1'b0; float_op_i = '0;
        operand1_i = '0; operand2_i = '0; operand3_i = '0; tag_i = '0;
        mul_done_i = 1'b0; div_done_i = 1'b0; add_done_i = 1'b0;
        mul_result_i = '0; div_result_i = '0; add_result_i = '0;
        result_ready_i = 1'b0;
        repeat (3) tick();
        rst_i = 1'b1;

        // reset state
        check("rst_ready", issue_ready_o, 1);
        check("rst_valid", result_valid_o, 0);
        check("rst_starts", {mul_start_o, div_start_o, add_start_o}, 0);
        check("rst_err_ill", {error_o, illegal_op_o, busy_o}, 0);
        check("rst_result", result_o, 0);
        check("rst_addop1", add_op1_o, 0);

        // FADD with 3-cycle adder, then back-pressure for 5 cycles
        issue(5'd6, 32'h3F80_0000, 32'h4000_0000, 32'h0, 5'd7);
        check("fadd_start", {mul_start_o, div_start_o, add_start_o}, 3'b001);
        check("fadd_sub", add_sub_o, 0);
        check("fadd_ops", {add_op1_o, add_op2_o}, {32'h3F80_0000, 32'h4000_0000});
        check("fadd_ready", issue_ready_o, 0);
        tick();
        check("fadd_start_1cyc", add_start_o, 0);
        pulse_done(2, 2, 32'h4040_0000);
        check("fadd_valid", result_valid_o, 1);
        check("fadd_result", result_o, 32'h4040_0000);
        check("fadd_tag", result_tag_o, 5'd7);
        check("fadd_err", error_o, 0);
        issue_valid_i = 1'b1; float_op_i = 5'd8; tag_i = 5'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_resp", {result_valid_o, result_o, result_tag_o, error_o},
                  {1'b1, 32'h4040_0000, 5'd7, 1'b0});
            check("hold_noacc", {issue_ready_o, mul_start_o}, 0);
        end
        issue_valid_i = 1'b0;
        handshake();
        check("fadd_done_valid", result_valid_o, 0);
        check("fadd_done_ready", issue_ready_o, 1);

        // fused ops: mul 2 cycles, add 2 cycles
        for (int k = 0; k < 4; k++) begin
            issue(fz_op[k], 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 5'd3);
            check("fz_mulstart", {mul_start_o, add_start_o}, 2'b10);
            check("fz_mulops", {mul_op1_o, mul_op2_o}, {32'h4000_0000, 32'h4040_0000});
            pulse_done(0, 2, 32'h40C0_0000);
            check("fz_addstart", {mul_start_o, add_start_o}, 2'b01);
            check("fz_addop1", add_op1_o, fz_op1[k]);
            check("fz_addop2", add_op2_o, 32'h3F80_0000);
            check("fz_sub", add_sub_o, fz_sub[k]);
            pulse_done(2, 2, 32'h40E0_0000 + k);
            check("fz_result", {result_valid_o, result_o, result_tag_o, error_o},
                  {1'b1, 32'h40E0_0000 + k, 5'd3, 1'b0});
            handshake();
        end

        // FDIV watchdog: stray mul_done must be ignored
        issue(5'd9, 32'h4100_0000, 32'h4000_0000, 32'h0, 5'd9);
        check("div_start", div_start_o, 1);
        check("div_ops", {div_op1_o, div_op2_o}, {32'h4100_0000, 32'h4000_0000});
        begin
            int n = 0;
            while (!result_valid_o && n < 40) begin
                mul_done_i = (n == 3);
                tick();
                n++;
            end
            mul_done_i = 1'b0;
            check("wd_cycles", n, 16);
        end
        check("wd_result", {result_o, error_o, result_tag_o}, {32'h7FC0_0000, 1'b1, 5'd9});
        handshake();
        check("wd_err_clr", {error_o, result_valid_o}, 0);

        // next op after a timeout carries no error
        issue(5'd8, 32'h4000_0000, 32'h4080_0000, 32'h0, 5'd2);
        pulse_done(0, 1, 32'h4100_0000);
        check("fmul_result", {result_valid_o, result_o, error_o}, {1'b1, 32'h4100_0000, 1'b0});
        handshake();

        // done arriving on the timeout cycle wins
        issue(5'd9, 32'h4100_0000, 32'h4000_0000, 32'h0, 5'd4);
        pulse_done(1, 15, 32'h4080_0000);
        check("race_result", {result_valid_o, result_o, error_o}, {1'b1, 32'h4080_0000, 1'b0});
        handshake();

        // unsupported op
        issue(5'd10, 32'h4000_0000, 32'h0, 32'h0, 5'd5);
        check("ill_pulse", illegal_op_o, 1);
        check("ill_nostart", {mul_start_o, div_start_o, add_start_o, busy_o}, 0);
        check("ill_ready", issue_ready_o, 1);
        tick();
        check("ill_1cyc", illegal_op_o, 0);

        // reset during MUL_WAIT
        issue(5'd8, 32'h4000_0000, 32'h4000_0000, 32'h0, 5'd6);
        check("rmid_start", mul_start_o, 1);
        tick();
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        check("rmid_idle", {issue_ready_o, busy_o, mul_start_o}, 3'b100);
        check("rmid_clr", {mul_op1_o, result_o}, 0);
        pulse_done(0, 0, 32'h4080_0000);
        tick();
        check("rmid_late", {result_valid_o, busy_o, add_start_o}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the bench never hangs.
    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "bench time limit");
    end

endmodule
`default_nettype wire
